// File: rtl/gray_pkg.sv
// Shared constants for the Gray-code link receiver: FSM state encoding,
// default count width and error-counter width.
package gray_pkg;

  localparam int GRAY_WIDTH_DEF = 3;
  localparam int ERRCNT_W       = 8;

  localparam logic [1:0] UNLOCKED = 2'd0;
  localparam logic [1:0] TRACK    = 2'd1;
  localparam logic [1:0] FAULT    = 2'd2;

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary decoder. Each binary bit is the XOR of all
// Gray bits at or above its position.
module gray_to_bin #(
  parameter int WIDTH = gray_pkg::GRAY_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Running XOR from the MSB down; a local accumulator avoids a
  // combinational self-read of the output vector.
  always_comb begin
    logic acc;
    acc = 1'b0;
    bin = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      acc    = acc ^ gray[i];
      bin[i] = acc;
    end
  end

endmodule

// File: rtl/gray_rx.sv
// Receiver for the Gray-code counter link. Decodes qualified Gray samples,
// checks that each accepted value is the +1 successor of the last one and
// reports step, wrap and sticky protocol errors.
// Optional feature: define GRAY_RX_ERRCNT_EN to add the saturating 8-bit
// ErrCount output, which counts TRACK->FAULT transitions and is cleared
// only by Reset_n.
//
// state    | meaning
// ---------+---------------------------------------------------------
// UNLOCKED | no reference yet; next Valid sample is captured as-is
// TRACK    | reference held; each sample must repeat or advance by 1
// FAULT    | illegal transition seen; samples ignored until Clear
module gray_rx
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH_DEF
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Valid,
  input  logic [WIDTH-1:0] Gray,
  input  logic             Clear,
  output logic [WIDTH-1:0] Binary,
  output logic             Locked,
  output logic             Step,
  output logic             Wrap,
`ifdef GRAY_RX_ERRCNT_EN
  output logic             Error,
  output logic [ERRCNT_W-1:0] ErrCount
`else
  output logic             Error
`endif
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] in_bin;
  logic [WIDTH-1:0] delta;

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] bin_q,    bin_d;
  logic             locked_q, locked_d;
  logic             step_q,   step_d;
  logic             wrap_q,   wrap_d;
  logic             err_q,    err_d;
  logic             to_fault;

  gray_to_bin #(.WIDTH(WIDTH)) u_dec (
    .gray (Gray),
    .bin  (in_bin)
  );

  // Modular distance from the last accepted count; natural WIDTH-bit wrap.
  assign delta = in_bin - bin_q;

  // Next-state and output-register logic; Clear overrides any sample.
  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    locked_d = locked_q;
    err_d    = err_q;
    step_d   = 1'b0;
    wrap_d   = 1'b0;
    to_fault = 1'b0;
    if (Clear) begin
      state_d  = UNLOCKED;
      bin_d    = '0;
      locked_d = 1'b0;
      err_d    = 1'b0;
    end else if (Valid) begin
      case (state_q)
        UNLOCKED: begin
          bin_d    = in_bin;
          locked_d = 1'b1;
          state_d  = TRACK;
        end
        TRACK: begin
          if (delta == ONE) begin
            bin_d  = in_bin;
            step_d = 1'b1;
            wrap_d = &bin_q;
          end else if (delta != '0) begin
            state_d  = FAULT;
            err_d    = 1'b1;
            to_fault = 1'b1;
          end
        end
        FAULT: ;
        default: state_d = UNLOCKED;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= UNLOCKED;
      bin_q    <= '0;
      locked_q <= 1'b0;
      step_q   <= 1'b0;
      wrap_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      locked_q <= locked_d;
      step_q   <= step_d;
      wrap_q   <= wrap_d;
      err_q    <= err_d;
    end
  end

  assign Binary = bin_q;
  assign Locked = locked_q;
  assign Step   = step_q;
  assign Wrap   = wrap_q;
  assign Error  = err_q;

`ifdef GRAY_RX_ERRCNT_EN
  logic [ERRCNT_W-1:0] errcnt_q, errcnt_d;

  // Saturating count of TRACK->FAULT transitions; Clear does not touch it.
  always_comb begin
    errcnt_d = errcnt_q;
    if (to_fault && (errcnt_q != {ERRCNT_W{1'b1}}))
      errcnt_d = errcnt_q + 1'b1;
  end

  // Error counter register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) errcnt_q <= '0;
    else          errcnt_q <= errcnt_d;
  end

  assign ErrCount = errcnt_q;
`else
  logic unused_to_fault;
  assign unused_to_fault = to_fault;
`endif

endmodule

// File: tb/tb_gray_rx.sv
// Directed, table-driven bench for gray_rx at WIDTH = 3.
module tb_gray_rx;

  localparam int W = 3;

  typedef struct {
    logic         clear;
    logic         valid;
    logic [W-1:0] gray;
    logic [W-1:0] e_bin;
    logic         e_locked;
    logic         e_step;
    logic         e_wrap;
    logic         e_err;
    string        name;
  } vec_t;

  logic         Clk = 1'b0;
  logic         Reset_n;
  logic         Valid;
  logic [W-1:0] Gray;
  logic         Clear;
  logic [W-1:0] Binary;
  logic         Locked;
  logic         Step;
  logic         Wrap;
  logic         Error;
`ifdef GRAY_RX_ERRCNT_EN
  logic [7:0]   ErrCount;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vq[$];

  gray_rx #(.WIDTH(W)) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Valid    (Valid),
    .Gray     (Gray),
    .Clear    (Clear),
    .Binary   (Binary),
    .Locked   (Locked),
    .Step     (Step),
    .Wrap     (Wrap),
`ifdef GRAY_RX_ERRCNT_EN
    .Error    (Error),
    .ErrCount (ErrCount)
`else
    .Error    (Error)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic add(input logic c, input logic v, input logic [W-1:0] g,
                     input logic [W-1:0] b, input logic l, input logic s,
                     input logic w, input logic e, input string nm);
    vec_t t;
    t.clear = c; t.valid = v; t.gray = g;
    t.e_bin = b; t.e_locked = l; t.e_step = s; t.e_wrap = w; t.e_err = e;
    t.name = nm;
    vq.push_back(t);
  endtask

  task automatic check_out(input string nm, input logic [W-1:0] b,
                           input logic l, input logic s, input logic w,
                           input logic e);
    n_tests++;
    if ({Binary, Locked, Step, Wrap, Error} !== {b, l, s, w, e}) begin
      n_fail++;
      $display("FAIL %s: got bin=%0d lock=%b step=%b wrap=%b err=%b, want bin=%0d lock=%b step=%b wrap=%b err=%b",
               nm, Binary, Locked, Step, Wrap, Error, b, l, s, w, e);
    end
  endtask

  task automatic check_cnt(input string nm, input int exp);
`ifdef GRAY_RX_ERRCNT_EN
    n_tests++;
    if (int'(ErrCount) != exp) begin
      n_fail++;
      $display("FAIL %s: got ErrCount=%0d, want %0d", nm, ErrCount, exp);
    end
`else
    if (nm.len() < 0 || exp < 0) $display("unreachable");
`endif
  endtask

  task automatic apply(input vec_t t);
    Clear = t.clear; Valid = t.valid; Gray = t.gray;
    @(posedge Clk);
    #1;
    check_out(t.name, t.e_bin, t.e_locked, t.e_step, t.e_wrap, t.e_err);
  endtask

  task automatic run_table(input int from, input int to);
    for (int i = from; i < to; i++) apply(vq[i]);
  endtask

  initial begin
    vec_t t;
    //  clr vld gray   bin lock step wrap err
    add(0, 1, 3'b000, 3'd0, 1, 0, 0, 0, "lock0");
    add(0, 1, 3'b001, 3'd1, 1, 1, 0, 0, "step1");
    add(0, 1, 3'b011, 3'd2, 1, 1, 0, 0, "step2");
    add(0, 1, 3'b010, 3'd3, 1, 1, 0, 0, "step3");
    add(0, 1, 3'b110, 3'd4, 1, 1, 0, 0, "step4");
    add(0, 1, 3'b111, 3'd5, 1, 1, 0, 0, "step5");
    add(0, 1, 3'b101, 3'd6, 1, 1, 0, 0, "step6");
    add(0, 1, 3'b100, 3'd7, 1, 1, 0, 0, "step7");
    add(0, 1, 3'b000, 3'd0, 1, 1, 1, 0, "wrap0");
    add(0, 0, 3'b101, 3'd0, 1, 0, 0, 0, "novalid");
    add(1, 0, 3'b000, 3'd0, 0, 0, 0, 0, "clear1");
    add(0, 1, 3'b001, 3'd1, 1, 0, 0, 0, "relock1");
    add(0, 1, 3'b001, 3'd1, 1, 0, 0, 0, "hold_a");
    add(0, 1, 3'b001, 3'd1, 1, 0, 0, 0, "hold_b");
    add(0, 0, 3'b111, 3'd1, 1, 0, 0, 0, "novalid2");
    add(0, 1, 3'b010, 3'd1, 1, 0, 0, 1, "jump");       // idx 15
    add(0, 1, 3'b011, 3'd1, 1, 0, 0, 1, "fault_ign");  // idx 16
    add(1, 1, 3'b110, 3'd0, 0, 0, 0, 0, "clr_valid");
    add(0, 1, 3'b110, 3'd4, 1, 0, 0, 0, "relock4");
    add(0, 1, 3'b111, 3'd5, 1, 1, 0, 0, "step4to5");
    add(1, 0, 3'b000, 3'd0, 0, 0, 0, 0, "clear2");
    add(0, 1, 3'b011, 3'd2, 1, 0, 0, 0, "lock2");
    add(0, 1, 3'b001, 3'd2, 1, 0, 0, 1, "backward");   // idx 22
    add(1, 0, 3'b000, 3'd0, 0, 0, 0, 0, "clear3");     // idx 23
    add(0, 1, 3'b111, 3'd5, 1, 0, 0, 0, "lock5");      // idx 24
    add(0, 1, 3'b111, 3'd5, 1, 0, 0, 0, "relock_rst"); // idx 25

    Reset_n = 1'b0; Valid = 1'b0; Clear = 1'b0; Gray = '0;
    #12;
    check_out("reset", 3'd0, 0, 0, 0, 0);
    check_cnt("reset_cnt", 0);
    #5 Reset_n = 1'b1;

    run_table(0, 16);
    check_cnt("cnt_jump", 1);
    run_table(16, 23);
    check_cnt("cnt_back", 2);
    run_table(23, 25);
    check_cnt("cnt_after_clear", 2);

    // Asynchronous reset between edges: outputs drop without a clock edge.
    Valid = 1'b0;
    #3 Reset_n = 1'b0;
    #1;
    check_out("async_rst", 3'd0, 0, 0, 0, 0);
    check_cnt("async_rst_cnt", 0);
    #2 Reset_n = 1'b1;
    t = vq[25];
    apply(t);

    // A Step pulse lasts exactly one cycle.
    apply(vq[6]);
    Valid = 1'b0;
    @(posedge Clk); #1;
    check_out("step_one_cycle", 3'd6, 1, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_rx.md
# gray_rx

Receiving end of the Gray-code counter link. It samples a WIDTH-bit Gray-coded count on qualified cycles, converts it to binary, and checks that each new value is the legal next step. It reports advance, wrap-around and protocol errors. It sits downstream of the Gray counter and gives binary-domain logic a checked count.

## Interface
Parameters:
- WIDTH, 3: width of the Gray input and binary output; minimum 2.

Ports:
- Clk  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous, active-low reset.
- Valid  in  1  Gray sample is qualified this cycle.
- Gray  in  WIDTH  Gray-coded count from the transmitter.
- Clear  in  1  leave FAULT or UNLOCKED and re-acquire.
- Binary  out  WIDTH  last accepted count, in binary.
- Locked  out  1  a reference value has been captured.
- Step  out  1  one-cycle pulse: count advanced by +1.
- Wrap  out  1  one-cycle pulse: count went from all-ones to 0; always coincides with Step.
- Error  out  1  sticky illegal-transition flag.
- ErrCount  out  8  illegal-transition count; present only with GRAY_RX_ERRCNT_EN.

## Operation
- Decode: in_bin[WIDTH-1] = Gray[WIDTH-1]; in_bin[i] = in_bin[i+1] ^ Gray[i].
- Delta = (in_bin - Binary) mod 2^WIDTH, computed at WIDTH bits with natural wrap.
- States: UNLOCKED, TRACK, FAULT.
- UNLOCKED: on Valid, Binary <= in_bin, Locked <= 1, next state TRACK. No Step or Wrap.
- TRACK, Valid with delta == 0: hold; no pulses.
- TRACK, Valid with delta == 1: Binary <= in_bin, Step = 1. Wrap = 1 if the old Binary is all-ones.
- TRACK, Valid with any other delta: next state FAULT, Error <= 1, Binary keeps the last good value. Other deltas include the backward step 2^WIDTH-1 and any multi-bit change.
- FAULT: Valid samples are ignored; Binary, Locked and Error hold.
- Clear in any state: next state UNLOCKED, Locked <= 0, Error <= 0, Binary <= 0.
- Clear and Valid together: Clear wins and the sample is discarded.
- Valid low: all registers hold; Step and Wrap are 0.

## Timing
- All outputs are registered. A sample taken at edge k is reflected after edge k. Step and Wrap are high for exactly one cycle, edge k to edge k+1.
- Back-to-back Valid is supported; throughput is one sample per cycle.
- Reset_n low, asynchronously and regardless of the clock:
  - state = UNLOCKED;
  - Binary = 0, Locked = 0, Step = 0, Wrap = 0, Error = 0, ErrCount = 0.
- Deasserting Reset_n mid-stream: the first Valid after release re-acquires, with no error. The release edge is synchronised externally.

## Configuration
- GRAY_RX_ERRCNT_EN defined:
  - ErrCount exists and increments on each TRACK->FAULT transition.
  - It saturates at 255.
  - It is cleared only by Reset_n, not by Clear.
- GRAY_RX_ERRCNT_EN undefined: the port and its counter logic are absent. All other behaviour is identical.

## Structure
- Shared package gray_pkg holds:
  - the state encoding localparams (UNLOCKED = 2'd0, TRACK = 2'd1, FAULT = 2'd2);
  - the default WIDTH;
  - the ErrCount width of 8.
- Sub-module gray_to_bin: combinational, WIDTH-parameterised decoder. gray_rx instantiates it once for the input. The counter block may reuse it for self-checks.
- The remaining logic is one FSM, a delta subtractor and the output registers, all inside gray_rx.

## Test plan
All scenarios use WIDTH = 3.
- Full cycle: after reset, Valid with Gray 000, 001, 011, 010, 110, 111, 101, 100, 000.
  - Binary reads 0,1,2,3,4,5,6,7,0.
  - Locked = 1 after the first sample.
  - Step pulses 8 times; Wrap pulses only on the final sample.
- Repeat/hold:
  - Gray 001 held for 3 Valid cycles gives Binary = 1 and no Step.
  - Valid low with Gray changing gives no output change.
- Illegal jump: lock on 001, then feed 010 (binary 3, delta 2).
  - Error = 1, state FAULT, Binary stays 1.
  - A further 011 is ignored.
  - With the macro, ErrCount = 1.
- Backward step: lock on 011, then feed 001 (binary 2 -> 1). Error = 1 and no Step.
- Clear: from FAULT, Clear = 1 with Valid = 1 and Gray 110 in the same cycle.
  - Result: UNLOCKED, Error = 0, Binary = 0; the sample is discarded.
  - The next Valid with 110 gives Binary = 4 and Locked = 1, with no Step.
- Async reset mid-stream: drop Reset_n between clock edges while at Binary = 5.
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After release, Valid with 111 re-locks at Binary = 5 with no Error.
